// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the SDRAM command front end: command and FSM encodings,
// timing-register layout and its reset value.
package sdram_ctrl_pkg;

   typedef enum logic [2:0] {
      CmdNop       = 3'b000,
      CmdReada     = 3'b001,
      CmdWritea    = 3'b010,
      CmdRefresh   = 3'b011,
      CmdPrecharge = 3'b100,
      CmdLoadMode  = 3'b101,
      CmdLoadReg1  = 3'b110,
      CmdLoadReg2  = 3'b111
   } cmd_e;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIssue   = 2'd1,
      StWaitAck = 2'd2,
      StRelease = 2'd3
   } state_e;

   // Field order matches the payload bit positions: cl[1:0] rc[3:2] rrd[7:4] pm[8] bl[12:9].
   typedef struct packed {
      logic [3:0] bl;
      logic       pm;
      logic [3:0] rrd;
      logic [1:0] rc;
      logic [1:0] cl;
   } timing_t;

   localparam int unsigned TimingW = $bits(timing_t);

   localparam timing_t TimingReset = '{bl: 4'd8, pm: 1'b0, rrd: 4'd1, rc: 2'd3, cl: 2'd3};

endpackage

// File: rtl/refresh_timer.sv
// Periodic refresh timer: down-counter reloaded from a programmable period,
// raising a sticky refresh request on every expiry.
module refresh_timer #(
   parameter int unsigned RFW = 16
) (
   input  logic           clk0,
   input  logic           reset,
   input  logic [RFW-1:0] period,
   input  logic           load,
   input  logic           ref_ack,
   output logic           ref_req
);

   logic [RFW-1:0] r_period;
   logic [RFW-1:0] r_cnt;
   logic           r_ref_req;
   logic           w_expire;

   // A reload in the same cycle masks the expiry of the old count.
   always_comb begin
      w_expire = 1'b0;
      if (!load && (r_period != '0) && (r_cnt == '0)) begin
         w_expire = 1'b1;
      end
   end

   always_ff @(posedge clk0) begin
      if (reset) begin
         r_period  <= '0;
         r_cnt     <= '0;
         r_ref_req <= 1'b0;
      end else begin
         if (load) begin
            r_period <= period;
            r_cnt    <= period;
         end else if (r_period != '0) begin
            if (r_cnt == '0) begin
               r_cnt <= r_period;
            end else begin
               r_cnt <= r_cnt - RFW'(1);
            end
         end

         if (w_expire) begin
            r_ref_req <= 1'b1;
         end else if (ref_ack) begin
            r_ref_req <= 1'b0;
         end
      end
   end

   assign ref_req = r_ref_req;

endmodule

// File: rtl/cmd_decode.sv
// Host command decoder: captures a command, issues one registered strobe for it,
// then waits for the acknowledge and for the host to return to NOP.
module cmd_decode
   import sdram_ctrl_pkg::*;
#(
   parameter int unsigned ASIZE = 23,
   parameter int unsigned RFW   = 16
) (
   input  logic             clk0,
   input  logic             reset,
   input  logic [2:0]       cmd,
   input  logic [ASIZE-1:0] addr,
   input  logic             cmdack,
   input  logic             ref_ack,
   output logic             do_read,
   output logic             do_write,
   output logic             do_refresh,
   output logic             do_precharge,
   output logic             do_load_mode,
   output logic             load_time,
   output logic             load_rfcnt,
   output logic [ASIZE-1:0] cmd_addr,
   output logic [1:0]       sc_cl,
   output logic [1:0]       sc_rc,
   output logic [3:0]       sc_rrd,
   output logic             sc_pm,
   output logic [3:0]       sc_bl,
   output logic             ref_req
);

   state_e           r_state;
   state_e           w_state_d;
   cmd_e             r_cmd;
   logic [ASIZE-1:0] r_cmd_addr;
   timing_t          r_timing;

   logic r_do_read, r_do_write, r_do_refresh, r_do_precharge, r_do_load_mode;
   logic r_load_time, r_load_rfcnt;

   logic w_capture, w_issue;
   logic w_do_read_d, w_do_write_d, w_do_refresh_d, w_do_precharge_d, w_do_load_mode_d;
   logic w_load_time_d, w_load_rfcnt_d;

   always_ff @(posedge clk0) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_capture = 1'b0;
      w_issue   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (cmd_e'(cmd) != CmdNop) begin
               w_capture = 1'b1;
               w_state_d = StIssue;
            end
         end
         StIssue: begin
            w_issue   = 1'b1;
            w_state_d = StWaitAck;
         end
         StWaitAck: begin
            if (cmdack) begin
               w_state_d = StRelease;
            end
         end
         StRelease: begin
            // A command still held here has already been issued; wait for NOP.
            if (cmd_e'(cmd) == CmdNop) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase

      w_do_read_d       = w_issue && (r_cmd == CmdReada);
      w_do_write_d      = w_issue && (r_cmd == CmdWritea);
      w_do_refresh_d    = w_issue && (r_cmd == CmdRefresh);
      w_do_precharge_d  = w_issue && (r_cmd == CmdPrecharge);
      w_do_load_mode_d  = w_issue && (r_cmd == CmdLoadMode);
      w_load_time_d     = w_issue && (r_cmd == CmdLoadReg1);
      w_load_rfcnt_d    = w_issue && (r_cmd == CmdLoadReg2);
   end

   always_ff @(posedge clk0) begin
      if (reset) begin
         r_cmd          <= CmdNop;
         r_cmd_addr     <= '0;
         r_timing       <= TimingReset;
         r_do_read      <= 1'b0;
         r_do_write     <= 1'b0;
         r_do_refresh   <= 1'b0;
         r_do_precharge <= 1'b0;
         r_do_load_mode <= 1'b0;
         r_load_time    <= 1'b0;
         r_load_rfcnt   <= 1'b0;
      end else begin
         if (w_capture) begin
            r_cmd      <= cmd_e'(cmd);
            r_cmd_addr <= addr;
         end
         if (w_load_time_d) begin
            r_timing <= timing_t'(r_cmd_addr[TimingW-1:0]);
         end
         r_do_read      <= w_do_read_d;
         r_do_write     <= w_do_write_d;
         r_do_refresh   <= w_do_refresh_d;
         r_do_precharge <= w_do_precharge_d;
         r_do_load_mode <= w_do_load_mode_d;
         r_load_time    <= w_load_time_d;
         r_load_rfcnt   <= w_load_rfcnt_d;
      end
   end

   refresh_timer #(
      .RFW (RFW)
   ) u_refresh_timer (
      .clk0    (clk0),
      .reset   (reset),
      .period  (r_cmd_addr[RFW-1:0]),
      .load    (w_load_rfcnt_d),
      .ref_ack (ref_ack),
      .ref_req (ref_req)
   );

   assign do_read      = r_do_read;
   assign do_write     = r_do_write;
   assign do_refresh   = r_do_refresh;
   assign do_precharge = r_do_precharge;
   assign do_load_mode = r_do_load_mode;
   assign load_time    = r_load_time;
   assign load_rfcnt   = r_load_rfcnt;
   assign cmd_addr     = r_cmd_addr;
   assign sc_cl        = r_timing.cl;
   assign sc_rc        = r_timing.rc;
   assign sc_rrd       = r_timing.rrd;
   assign sc_pm        = r_timing.pm;
   assign sc_bl        = r_timing.bl;

endmodule

// File: tb/tb_cmd_decode.sv
// Directed bench for cmd_decode: command handshake, timing/refresh register loads,
// refresh request timing and reset behaviour.
module tb_cmd_decode;

   localparam int unsigned ASIZE = 23;
   localparam int unsigned RFW   = 16;

   logic             clk0;
   logic             reset;
   logic [2:0]       cmd;
   logic [ASIZE-1:0] addr;
   logic             cmdack;
   logic             ref_ack;
   logic             do_read, do_write, do_refresh, do_precharge, do_load_mode;
   logic             load_time, load_rfcnt;
   logic [ASIZE-1:0] cmd_addr;
   logic [1:0]       sc_cl, sc_rc;
   logic [3:0]       sc_rrd, sc_bl;
   logic             sc_pm;
   logic             ref_req;

   logic [6:0]  strobes;
   logic [12:0] fields;

   int n_cmp;
   int n_bad;

   assign strobes = {do_read, do_write, do_refresh, do_precharge, do_load_mode, load_time,
                     load_rfcnt};
   assign fields  = {sc_cl, sc_rc, sc_rrd, sc_pm, sc_bl};

   cmd_decode #(
      .ASIZE (ASIZE),
      .RFW   (RFW)
   ) dut (
      .clk0         (clk0),
      .reset        (reset),
      .cmd          (cmd),
      .addr         (addr),
      .cmdack       (cmdack),
      .ref_ack      (ref_ack),
      .do_read      (do_read),
      .do_write     (do_write),
      .do_refresh   (do_refresh),
      .do_precharge (do_precharge),
      .do_load_mode (do_load_mode),
      .load_time    (load_time),
      .load_rfcnt   (load_rfcnt),
      .cmd_addr     (cmd_addr),
      .sc_cl        (sc_cl),
      .sc_rc        (sc_rc),
      .sc_rrd       (sc_rrd),
      .sc_pm        (sc_pm),
      .sc_bl        (sc_bl),
      .ref_req      (ref_req)
   );

   initial clk0 = 1'b0;
   always #5 clk0 = ~clk0;

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   // Call while in WAIT_ACK: ack, then NOP so RELEASE returns to IDLE.
   task automatic ack_and_release();
      cmdack = 1'b1;
      tick();
      cmdack = 1'b0;
      cmd    = 3'b000;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd = 3'b000; addr = '0; cmdack = 1'b0; ref_ack = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (strobes !== 7'b0) begin
         n_bad++; $display("FAIL reset_strobes: got %b want %b", strobes, 7'b0);
      end
      n_cmp++;
      if (cmd_addr !== 23'h0) begin
         n_bad++; $display("FAIL reset_cmd_addr: got %h want %h", cmd_addr, 23'h0);
      end
      n_cmp++;
      if (fields !== {2'd3, 2'd3, 4'd1, 1'b0, 4'd8}) begin
         n_bad++; $display("FAIL reset_timing: got %h want %h", fields,
                           {2'd3, 2'd3, 4'd1, 1'b0, 4'd8});
      end
      n_cmp++;
      if (ref_req !== 1'b0) begin
         n_bad++; $display("FAIL reset_ref_req: got %b want 0", ref_req);
      end
      reset = 1'b0;
   endtask

   task automatic test_read();
      int pulses;
      pulses = 0;
      cmd = 3'b001; addr = 23'h12345;
      tick();
      n_cmp++;
      if (do_read !== 1'b0) begin
         n_bad++; $display("FAIL read_latency: got %b want 0", do_read);
      end
      n_cmp++;
      if (cmd_addr !== 23'h12345) begin
         n_bad++; $display("FAIL read_capture: got %h want %h", cmd_addr, 23'h12345);
      end
      addr = 23'h70F0F;
      tick();
      n_cmp++;
      if (do_read !== 1'b1) begin
         n_bad++; $display("FAIL read_strobe: got %b want 1", do_read);
      end
      pulses += int'(do_read);
      tick(); pulses += int'(do_read);
      tick(); pulses += int'(do_read);
      cmdack = 1'b1;
      tick(); pulses += int'(do_read);
      cmdack = 1'b0;
      repeat (2) begin
         tick(); pulses += int'(do_read);
      end
      n_cmp++;
      if (pulses != 1) begin
         n_bad++; $display("FAIL read_single_pulse: got %0d want 1", pulses);
      end
      n_cmp++;
      if (cmd_addr !== 23'h12345) begin
         n_bad++; $display("FAIL read_addr_stable: got %h want %h", cmd_addr, 23'h12345);
      end
      cmd = 3'b000;
      tick();
   endtask

   task automatic test_load_reg1();
      cmd = 3'b110; addr = 23'h01A35;
      tick();
      n_cmp++;
      if (load_time !== 1'b0 || fields !== {2'd3, 2'd3, 4'd1, 1'b0, 4'd8}) begin
         n_bad++; $display("FAIL load_time_early: got %b/%h want 0/%h", load_time, fields,
                           {2'd3, 2'd3, 4'd1, 1'b0, 4'd8});
      end
      cmd = 3'b000;
      tick();
      n_cmp++;
      if (load_time !== 1'b1) begin
         n_bad++; $display("FAIL load_time_strobe: got %b want 1", load_time);
      end
      n_cmp++;
      if (fields !== {2'd1, 2'd1, 4'd3, 1'b0, 4'd13}) begin
         n_bad++; $display("FAIL load_time_fields: got %h want %h", fields,
                           {2'd1, 2'd1, 4'd3, 1'b0, 4'd13});
      end
      tick();
      n_cmp++;
      if (load_time !== 1'b0) begin
         n_bad++; $display("FAIL load_time_width: got %b want 0", load_time);
      end
      ack_and_release();
   endtask

   task automatic test_refresh();
      int rises;
      cmd = 3'b111; addr = 23'h4;
      tick();
      cmd = 3'b000;
      tick();                                   // period 4 loaded, counter 4
      n_cmp++;
      if (load_rfcnt !== 1'b1 || ref_req !== 1'b0) begin
         n_bad++; $display("FAIL load_rfcnt_strobe: got %b/%b want 1/0", load_rfcnt, ref_req);
      end
      ack_and_release();
      rises = 0;
      repeat (2) begin
         tick(); rises += int'(ref_req);
      end
      n_cmp++;
      if (rises != 0) begin
         n_bad++; $display("FAIL refresh_early: got %0d want 0", rises);
      end
      tick();                                   // counter hit 0 on the previous edge
      n_cmp++;
      if (ref_req !== 1'b1) begin
         n_bad++; $display("FAIL refresh_first: got %b want 1", ref_req);
      end
      ref_ack = 1'b1;
      tick();
      ref_ack = 1'b0;
      n_cmp++;
      if (ref_req !== 1'b0) begin
         n_bad++; $display("FAIL ref_ack_clear: got %b want 0", ref_req);
      end
      repeat (3) tick();
      n_cmp++;
      if (ref_req !== 1'b0) begin
         n_bad++; $display("FAIL refresh_gap: got %b want 0", ref_req);
      end
      tick();
      n_cmp++;
      if (ref_req !== 1'b1) begin
         n_bad++; $display("FAIL refresh_period5: got %b want 1", ref_req);
      end
      ref_ack = 1'b1;
      tick();
      ref_ack = 1'b0;
      repeat (3) tick();
      ref_ack = 1'b1;                           // lands on the next expiry edge
      tick();
      ref_ack = 1'b0;
      n_cmp++;
      if (ref_req !== 1'b1) begin
         n_bad++; $display("FAIL expiry_vs_ack: got %b want 1", ref_req);
      end
      ref_ack = 1'b1;
      tick();
      ref_ack = 1'b0;
      n_cmp++;
      if (ref_req !== 1'b0) begin
         n_bad++; $display("FAIL ack_after_tie: got %b want 0", ref_req);
      end
      tick();
      tick();
      cmd = 3'b111; addr = 23'h2;
      tick();
      cmd = 3'b000;
      tick();                                   // reload coincides with expiry
      n_cmp++;
      if (load_rfcnt !== 1'b1 || ref_req !== 1'b0) begin
         n_bad++; $display("FAIL reload_vs_expiry: got %b/%b want 1/0", load_rfcnt, ref_req);
      end
      ack_and_release();
      n_cmp++;
      if (ref_req !== 1'b0) begin
         n_bad++; $display("FAIL new_period_early: got %b want 0", ref_req);
      end
      tick();
      n_cmp++;
      if (ref_req !== 1'b1) begin
         n_bad++; $display("FAIL new_period_expiry: got %b want 1", ref_req);
      end
      ref_ack = 1'b1; cmd = 3'b111; addr = 23'h0;
      tick();
      ref_ack = 1'b0; cmd = 3'b000;
      tick();                                   // period 0 loaded
      ack_and_release();
      rises = 0;
      repeat (12) begin
         tick(); rises += int'(ref_req);
      end
      n_cmp++;
      if (rises != 0) begin
         n_bad++; $display("FAIL refresh_disabled: got %0d want 0", rises);
      end
   endtask

   task automatic test_back_to_back();
      int lm;
      cmd = 3'b100; addr = 23'h2AAAA;
      tick();
      cmdack = 1'b1; cmd = 3'b000;              // ack during ISSUE must be ignored
      tick();
      cmdack = 1'b0;
      n_cmp++;
      if (do_precharge !== 1'b1) begin
         n_bad++; $display("FAIL precharge_strobe: got %b want 1", do_precharge);
      end
      tick();
      tick();
      cmd = 3'b101; addr = 23'h00321;
      lm = 0;
      repeat (3) begin
         tick(); lm += int'(do_load_mode);
      end
      n_cmp++;
      if (lm != 0) begin
         n_bad++; $display("FAIL wait_ack_ignores_cmd: got %0d want 0", lm);
      end
      n_cmp++;
      if (cmd_addr !== 23'h2AAAA) begin
         n_bad++; $display("FAIL addr_held_in_wait: got %h want %h", cmd_addr, 23'h2AAAA);
      end
      cmdack = 1'b1; cmd = 3'b000;
      tick();
      cmdack = 1'b0;
      tick();
      cmd = 3'b101; addr = 23'h00321;
      tick();
      cmd = 3'b000;
      tick();
      n_cmp++;
      if (do_load_mode !== 1'b1 || cmd_addr !== 23'h00321) begin
         n_bad++; $display("FAIL load_mode_after: got %b/%h want 1/%h", do_load_mode, cmd_addr,
                           23'h00321);
      end
      ack_and_release();
   endtask

   task automatic test_refresh_held();
      int refs;
      int reads;
      refs = 0;
      cmd = 3'b011; addr = 23'h00100;
      tick(); refs += int'(do_refresh);
      tick(); refs += int'(do_refresh);
      n_cmp++;
      if (do_refresh !== 1'b1) begin
         n_bad++; $display("FAIL refresh_strobe: got %b want 1", do_refresh);
      end
      tick(); refs += int'(do_refresh);
      cmdack = 1'b1;
      tick(); refs += int'(do_refresh);
      cmdack = 1'b0;
      repeat (4) begin
         tick(); refs += int'(do_refresh);
      end
      n_cmp++;
      if (refs != 1) begin
         n_bad++; $display("FAIL refresh_held_once: got %0d want 1", refs);
      end
      cmd = 3'b001;
      reads = 0;
      repeat (4) begin
         tick(); reads += int'(do_read);
      end
      n_cmp++;
      if (reads != 0) begin
         n_bad++; $display("FAIL release_holds: got %0d want 0", reads);
      end
      cmd = 3'b000;
      tick();
      cmd = 3'b001; addr = 23'h55555;
      tick();
      tick();
      n_cmp++;
      if (do_read !== 1'b1 || cmd_addr !== 23'h55555) begin
         n_bad++; $display("FAIL read_after_release: got %b/%h want 1/%h", do_read, cmd_addr,
                           23'h55555);
      end
      cmd = 3'b000;
      tick();
      ack_and_release();
   endtask

   task automatic test_reset_mid();
      int writes;
      cmd = 3'b010; addr = 23'h00ABC;
      tick();
      tick();
      n_cmp++;
      if (do_write !== 1'b1) begin
         n_bad++; $display("FAIL write_strobe: got %b want 1", do_write);
      end
      tick();                                   // now in WAIT_ACK
      reset = 1'b1;
      tick();
      n_cmp++;
      if (strobes !== 7'b0 || cmd_addr !== 23'h0 || ref_req !== 1'b0) begin
         n_bad++; $display("FAIL midreset_outputs: got %b/%h/%b want 0/0/0", strobes, cmd_addr,
                           ref_req);
      end
      n_cmp++;
      if (fields !== {2'd3, 2'd3, 4'd1, 1'b0, 4'd8}) begin
         n_bad++; $display("FAIL midreset_timing: got %h want %h", fields,
                           {2'd3, 2'd3, 4'd1, 1'b0, 4'd8});
      end
      tick();
      n_cmp++;
      if (strobes !== 7'b0) begin
         n_bad++; $display("FAIL reset_held_strobes: got %b want 0", strobes);
      end
      reset = 1'b0; cmd = 3'b000;
      writes = 0;
      repeat (5) begin
         tick(); writes += int'(do_write);
      end
      n_cmp++;
      if (writes != 0) begin
         n_bad++; $display("FAIL abandoned_write: got %0d want 0", writes);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_read();
      test_load_reg1();
      test_refresh();
      test_back_to_back();
      test_refresh_held();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
